// File: rtl/yarp_pkg.sv
// Shared types for the YARP memory arbiter: FSM states, transaction owner
// and load/store access sizes.
package yarp_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2,
    ARB_ERR  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_t;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b11
  } mem_size_t;

  // Snapshot of the arbiter FSM for checkers bound onto the top.
  typedef struct packed {
    arb_state_t state;
    arb_owner_t owner;
    arb_owner_t last_owner;
  } arb_dbg_t;

endpackage

// File: rtl/yarp_lsu_align.sv
// Byte-lane handling for the data port: request-side byte enables, store
// replication and misalignment; response-side lane extraction and extension.
module yarp_lsu_align
  import yarp_pkg::*;
(
  input  logic [1:0]  req_lsb_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_wdata_i,
  output logic [3:0]  req_be_o,
  output logic [31:0] req_wdata_o,
  output logic        req_misaligned_o,
  input  logic [1:0]  rsp_lsb_i,
  input  logic [1:0]  rsp_size_i,
  input  logic        rsp_zext_i,
  input  logic [31:0] rsp_rdata_i,
  output logic [31:0] rsp_rdata_o
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  always_comb begin
    req_be_o         = 4'b1111;
    req_wdata_o      = req_wdata_i;
    req_misaligned_o = 1'b0;
    case (mem_size_t'(req_size_i))
      MEM_BYTE: begin
        req_be_o    = 4'b0001 << req_lsb_i;
        req_wdata_o = {4{req_wdata_i[7:0]}};
      end
      MEM_HALF: begin
        req_be_o         = 4'b0011 << {req_lsb_i[1], 1'b0};
        req_wdata_o      = {2{req_wdata_i[15:0]}};
        req_misaligned_o = req_lsb_i[0];
      end
      // The unused encoding 2'b10 is treated as a word access.
      default: begin
        req_misaligned_o = |req_lsb_i;
      end
    endcase
  end

  always_comb begin
    byte_sh     = rsp_rdata_i >> {rsp_lsb_i, 3'b000};
    half_sh     = rsp_rdata_i >> {rsp_lsb_i[1], 4'b0000};
    rsp_rdata_o = rsp_rdata_i;
    case (mem_size_t'(rsp_size_i))
      MEM_BYTE: rsp_rdata_o = {{24{~rsp_zext_i & byte_sh[7]}}, byte_sh[7:0]};
      MEM_HALF: rsp_rdata_o = {{16{~rsp_zext_i & half_sh[15]}}, half_sh[15:0]};
      default:  rsp_rdata_o = rsp_rdata_i;
    endcase
  end

endmodule

// File: rtl/yarp_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// load/store, one outstanding transaction at a time.
module yarp_mem_arbiter
  import yarp_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [1:0]        dm_byte_i,
  input  logic              dm_wr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  input  logic              dm_zero_extnd_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_err_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  // Handshakes: a requester holds req (and its payload) until it sees its gnt
  // pulse; gnt follows mem_gnt_i in ARB_REQ, rvalid follows mem_rvalid_i in
  // ARB_RESP, each lasting exactly one cycle. Memory-side gnt/rvalid are
  // ignored outside those states, so a late response after reset is dropped.

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  arb_owner_t        last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [1:0]        lsb_q, lsb_d;
  logic [1:0]        size_q, size_d;
  logic              zext_q, zext_d;

  arb_dbg_t          arb_dbg;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic              al_misaligned;
  logic [31:0]       al_rdata;
  logic              sel_data;
  logic              if_resp;
  logic              dm_resp;
  logic              unused_ok;

  yarp_lsu_align u_align (
    .req_lsb_i        (dm_addr_i[1:0]),
    .req_size_i       (dm_byte_i),
    .req_wdata_i      (dm_wdata_i),
    .req_be_o         (al_be),
    .req_wdata_o      (al_wdata),
    .req_misaligned_o (al_misaligned),
    .rsp_lsb_i        (lsb_q),
    .rsp_size_i       (size_q),
    .rsp_zext_i       (zext_q),
    .rsp_rdata_i      (mem_rdata_i),
    .rsp_rdata_o      (al_rdata)
  );

  // On a tie the requester that did not own the previous transaction wins.
  assign sel_data = dm_req_i & (~if_req_i | (last_q == OWN_FETCH));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    lsb_d   = lsb_q;
    size_d  = size_q;
    zext_d  = zext_q;
    case (state_q)
      ARB_IDLE: begin
        if (sel_data) begin
          owner_d = OWN_DATA;
          last_d  = OWN_DATA;
          addr_d  = {dm_addr_i[ADDR_W-1:2], 2'b00};
          be_d    = al_be;
          wdata_d = al_wdata;
          we_d    = dm_wr_i;
          lsb_d   = dm_addr_i[1:0];
          size_d  = dm_byte_i;
          zext_d  = dm_zero_extnd_i;
          state_d = al_misaligned ? ARB_ERR : ARB_REQ;
        end else if (if_req_i) begin
          owner_d = OWN_FETCH;
          last_d  = OWN_FETCH;
          addr_d  = {if_addr_i[ADDR_W-1:2], 2'b00};
          be_d    = 4'b1111;
          wdata_d = '0;
          we_d    = 1'b0;
          lsb_d   = 2'b00;
          size_d  = MEM_WORD;
          zext_d  = 1'b0;
          state_d = ARB_REQ;
        end
      end
      ARB_REQ:  if (mem_gnt_i) state_d = ARB_RESP;
      ARB_RESP: if (mem_rvalid_i) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_FETCH;
      last_q  <= OWN_FETCH;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      lsb_q   <= 2'b00;
      size_q  <= MEM_WORD;
      zext_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      lsb_q   <= lsb_d;
      size_q  <= size_d;
      zext_q  <= zext_d;
    end
  end

  assign arb_dbg = '{state: state_q, owner: owner_q, last_owner: last_q};

  assign mem_req_o   = (state_q == ARB_REQ);
  assign mem_addr_o  = addr_q;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;

  assign if_resp = (state_q == ARB_RESP) & (owner_q == OWN_FETCH) & mem_rvalid_i;
  assign dm_resp = (state_q == ARB_RESP) & (owner_q == OWN_DATA) & mem_rvalid_i;

  assign if_gnt_o    = (state_q == ARB_REQ) & (owner_q == OWN_FETCH) & mem_gnt_i;
  assign dm_gnt_o    = ((state_q == ARB_REQ) & (owner_q == OWN_DATA) & mem_gnt_i)
                     | (state_q == ARB_ERR);
  assign if_rvalid_o = if_resp;
  assign dm_rvalid_o = dm_resp | (state_q == ARB_ERR);
  assign dm_err_o    = (state_q == ARB_ERR);
  assign if_rdata_o  = if_resp ? mem_rdata_i : '0;
  // Stores and misaligned accesses report zero data.
  assign dm_rdata_o  = (dm_resp & ~we_q) ? al_rdata : '0;

  assign unused_ok = ^{if_addr_i[1:0], arb_dbg};

endmodule

// File: doc/yarp_mem_arbiter.md
# yarp_mem_arbiter

Sequential arbiter sharing a single memory port between the YARP instruction-fetch requester and the load/store requester. It sits between the core (fetch unit and data-memory interface driven by the control unit's `data_req`/`data_byte`/`data_wr`/`zero_extnd` signals) and the unified memory. It performs round-robin arbitration and runs one outstanding transaction at a time through a req/gnt/rvalid handshake. It also generates byte enables, replicates write data and sign- or zero-extends load data.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (fixed at 32; byte-lane logic assumes 4 lanes)

Ports:
- `clk` in 1 — core clock
- `reset_n` in 1 — synchronous, active-low reset
- `if_req_i` in 1 — fetch request, held until `if_gnt_o`
- `if_addr_i` in ADDR_W — fetch address; bits [1:0] ignored
- `if_gnt_o` out 1 — fetch request accepted
- `if_rvalid_o` out 1 — fetch data valid (1-cycle pulse)
- `if_rdata_o` out DATA_W — instruction word
- `dm_req_i` in 1 — data request, held until `dm_gnt_o`
- `dm_addr_i` in ADDR_W — byte address
- `dm_byte_i` in 2 — size: 00 byte, 01 half, 11 word
- `dm_wr_i` in 1 — 1 store, 0 load
- `dm_wdata_i` in DATA_W — store data, LSB-aligned
- `dm_zero_extnd_i` in 1 — 1 zero-extend load, 0 sign-extend
- `dm_gnt_o` out 1 — data request accepted
- `dm_rvalid_o` out 1 — load data or store completion (1-cycle pulse)
- `dm_rdata_o` out DATA_W — extended load data; 0 for stores and errors
- `dm_err_o` out 1 — misaligned access, valid with `dm_rvalid_o`
- `mem_req_o` out 1 — memory request
- `mem_addr_o` out ADDR_W — word-aligned address, {addr[ADDR_W-1:2],2'b00}
- `mem_we_o` out 1 — write enable
- `mem_be_o` out 4 — byte enables
- `mem_wdata_o` out DATA_W — lane-replicated store data
- `mem_gnt_i` in 1 — memory accepts request
- `mem_rvalid_i` in 1 — response (read data or write ack)
- `mem_rdata_i` in DATA_W — read word

## Operation
- States:
  - ARB_IDLE: arbitrate among pending requests.
  - ARB_REQ: `mem_req_o`=1; wait for `mem_gnt_i`.
  - ARB_RESP: wait for `mem_rvalid_i`.
  - ARB_ERR: one cycle, no memory access.
- **ARB_IDLE arbitration:**
  - One requester pending: select it.
  - Both pending: select the requester that is not `last_owner`. `last_owner` resets to FETCH, so data wins the first tie.
  - On selection, register owner, address, size, we, wdata, zero_extnd and addr[1:0]; update `last_owner`.
  - Next state: ARB_REQ, or ARB_ERR if the data access is misaligned.
- **Misaligned:** half with addr[0]=1, or word with addr[1:0]≠00.
- **ARB_REQ:** memory outputs driven from the registers. When `mem_gnt_i`=1, pulse `if_gnt_o` or `dm_gnt_o` for the owner (combinational from `mem_gnt_i`) and go to ARB_RESP.
- **ARB_RESP:** when `mem_rvalid_i`=1, pulse the owner's rvalid and go to ARB_IDLE.
- **ARB_ERR:** pulse `dm_gnt_o`, `dm_rvalid_o` and `dm_err_o` together; `dm_rdata_o`=0; go to ARB_IDLE.
- **Byte enables:**
  - byte: 0001<<a[1:0]
  - half: 0011<<{a[1],0}
  - word: 1111
- **Write data replication:**
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- **Load data:** select the lane using the registered a[1:0]; extend to 32 bits per `zero_extnd`. Fetch data passes through unmodified.
- **Ignored inputs:**
  - `mem_gnt_i` outside ARB_REQ.
  - `mem_rvalid_i` outside ARB_RESP, including a late response after reset.
- Requests arriving while busy stay pending and are held by the requester.

## Timing
- **Reset:** all outputs 0, state ARB_IDLE, `last_owner`=FETCH. Reset mid-transaction abandons the transaction; no gnt or rvalid is issued for it.
- **Minimum latency:** req at cycle N → `mem_req_o` at N+1. With `mem_gnt_i` at N+1, requester gnt is at N+1. `mem_rvalid_i` at N+2 gives owner rvalid at N+2.
- Response data and rvalid are combinational from `mem_rvalid_i`/`mem_rdata_i`; all other memory-side outputs are registered.
- **Back-to-back:** the next arbitration happens in the ARB_IDLE cycle after the response, giving ≥3 cycles per access.
- **Misaligned:** request at N → err/rvalid/gnt at N+1; `mem_req_o` never asserted.

## Structure
- Add to `yarp_pkg`:
  - `arb_state_t` {ARB_IDLE, ARB_REQ, ARB_RESP, ARB_ERR}
  - `arb_owner_t` {OWN_FETCH, OWN_DATA}
  - `mem_size_t` {MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b11}
- Sub-module `yarp_lsu_align`: combinational byte-enable generation, write replication, load lane extraction and extension, and misalignment detection.

## Test plan
- **Fetch only:** `if_addr_i`=0x100, memory grants immediately and returns 0x00500093 → `mem_addr_o`=0x100, `mem_be_o`=1111, `if_rvalid_o` with 0x00500093 at N+2.
- **Simultaneous fetch and data** from reset, both held: data granted first, fetch second. Keep both asserted: owners alternate D,F,D,F.
- **Signed byte load** at 0x203, `mem_rdata_i`=0x80FF_1234 → `mem_be_o`=1000, `dm_rdata_o`=0xFFFF_FF80. Same with `dm_zero_extnd_i`=1 → 0x0000_0080.
- **Half store** 0xABCD to 0x302 → `mem_addr_o`=0x300, `mem_be_o`=1100, `mem_wdata_o`=0xABCD_ABCD, `mem_we_o`=1. `dm_rvalid_o` on ack with `dm_rdata_o`=0.
- **Word load** at 0x401 → `dm_err_o`+`dm_rvalid_o` at N+1, no `mem_req_o`.
- **Memory stall and mid-flight reset:** `mem_gnt_i` held low 3 cycles → `mem_req_o` and registered outputs stable. `reset_n` low in ARB_RESP, then `mem_rvalid_i` after reset → no rvalid to either requester.
